fifo_merge_arbiter: RTL and testbench

FIFO_MERGE_ARBITER -- requirements
Module: fifo_merge_arbiter

---
 rtl/fifo_merge_arbiter_pkg.sv | 10 +
 rtl/rr_priority_select.sv | 38 +++
 rtl/fifo_merge_arbiter.sv | 151 +++++++++++++++
 tb/tb_fifo_merge_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_merge_arbiter_pkg.sv
// fifo_merge_arbiter_pkg
//   Shared encodings for the FIFO merge arbiter.
//   Provides the two arbiter states (legacy-style localparam constants).
package fifo_merge_arbiter_pkg;

  // Arbiter states: FREE searches round-robin, LOCKED keeps granting one port
  localparam logic [0:0] ST_FREE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select
//   Combinational round-robin search: returns the first asserted request bit
//   found scanning upward from 'start' with wrap-around.
// Ports:
//   req        request vector, one bit per port
//   start      index that has highest priority this cycle
//   grant      index of the selected request (0 when none)
//   any_valid  high when at least one request bit is set
module rr_priority_select #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      // start + off stays below 2*NUM_PORTS, so one subtraction wraps it
      idx = 32'(start) + off;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        grant     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_merge_arbiter.sv
// fifo_merge_arbiter
//   Merges NUM_PORTS first-word-fall-through FIFO read ports into one
//   downstream FIFO write port.  Arbitration is round-robin with bursts of up
//   to BURST consecutive grants to the same port.  Each popped word is tagged
//   with its source port id and held in a single output register.
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   in_empty_n    per-port data-available flags
//   in_read       per-port pop strobe (one-hot or zero)
//   in_read_ce    per-port read clock enable, tied high
//   in_dout       per-port head words, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n    downstream has space
//   out_write     downstream push strobe (holding register valid)
//   out_write_ce  downstream write clock enable, tied high
//   out_din       {source id, payload}
module fifo_merge_arbiter
  import fifo_merge_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned BURST      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           in_empty_n,
  output logic [NUM_PORTS-1:0]           in_read,
  output logic [NUM_PORTS-1:0]           in_read_ce,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
  input  logic                           out_full_n,
  output logic                           out_write,
  output logic                           out_write_ce,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] out_din
);

  localparam int unsigned OUT_WIDTH = ID_WIDTH + DATA_WIDTH;
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0]  BURST_MAX = 8'(BURST);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

  // Holding register
  logic                  valid_q, valid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Arbiter state
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] lock_port_q, lock_port_d;
  logic [7:0]       count_q, count_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             accept;
  logic             keep_lock;
  logic             pop;
  logic [IDX_W-1:0] pop_idx;
  logic [IDX_W-1:0] search_start;
  logic [IDX_W-1:0] rr_grant;
  logic             rr_any;

  // A word can enter whenever the register is empty or is draining this cycle
  assign accept = !valid_q || out_full_n;

  // Search begins just after the last grant, so on release the locked port
  // ranks last and is only re-granted when nothing else is waiting.
  assign search_start = (last_grant_q == LAST_PORT) ? '0 : last_grant_q + IDX_W'(1);

  assign keep_lock = (state_q == ST_LOCKED) && in_empty_n[lock_port_q] &&
                     (count_q < BURST_MAX);

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_priority_select (
    .req       (in_empty_n),
    .start     (search_start),
    .grant     (rr_grant),
    .any_valid (rr_any)
  );

  always_comb begin
    valid_d      = valid_q;
    id_d         = id_q;
    data_d       = data_q;
    state_d      = state_q;
    lock_port_d  = lock_port_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    pop          = 1'b0;
    pop_idx      = rr_grant;

    if (accept) begin
      if (keep_lock) begin
        pop     = 1'b1;
        pop_idx = lock_port_q;
        count_d = count_q + 8'd1;
      end else if (rr_any) begin
        pop          = 1'b1;
        pop_idx      = rr_grant;
        last_grant_d = rr_grant;
        lock_port_d  = rr_grant;
        count_d      = 8'd1;
        state_d      = (BURST > 1) ? ST_LOCKED : ST_FREE;
      end else begin
        state_d = ST_FREE;
        count_d = 8'd0;
      end

      // Either load the popped word or drain to empty
      valid_d = pop;
      if (pop) begin
        id_d   = ID_WIDTH'(pop_idx);
        data_d = in_dout[32'(pop_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset discards any pop decided this cycle, so the strobe is masked too
  always_comb begin
    in_read = '0;
    if (pop && !reset) begin
      in_read = NUM_PORTS'(1) << pop_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      id_q         <= '0;
      data_q       <= '0;
      state_q      <= ST_FREE;
      lock_port_q  <= '0;
      count_q      <= 8'd0;
      last_grant_q <= LAST_PORT;
    end else begin
      valid_q      <= valid_d;
      id_q         <= id_d;
      data_q       <= data_d;
      state_q      <= state_d;
      lock_port_q  <= lock_port_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_write    = valid_q;
  assign out_din      = OUT_WIDTH'({id_q, data_q});
  assign in_read_ce   = '1;
  assign out_write_ce = 1'b1;

endmodule

// File: tb/tb_fifo_merge_arbiter.sv
module tb_fifo_merge_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int ND = 3;

  logic          clk;
  logic          rst;
  logic [NP-1:0] en;
  logic          full;
  logic [NP*DW-1:0] dout;

  logic [NP-1:0]    rd  [ND];
  logic [NP-1:0]    rce [ND];
  logic             wr  [ND];
  logic             wce [ND];
  logic [IW+DW-1:0] dn  [ND];

  int total = 0;
  int bad   = 0;

  // Burst length of each instance
  int bl [ND] = '{1, 4, 2};

  fifo_merge_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST(1)) u_b1 (
    .clk(clk), .reset(rst), .in_empty_n(en), .in_read(rd[0]), .in_read_ce(rce[0]),
    .in_dout(dout), .out_full_n(full), .out_write(wr[0]), .out_write_ce(wce[0]),
    .out_din(dn[0]));
  fifo_merge_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST(4)) u_b4 (
    .clk(clk), .reset(rst), .in_empty_n(en), .in_read(rd[1]), .in_read_ce(rce[1]),
    .in_dout(dout), .out_full_n(full), .out_write(wr[1]), .out_write_ce(wce[1]),
    .out_din(dn[1]));
  fifo_merge_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST(2)) u_b2 (
    .clk(clk), .reset(rst), .in_empty_n(en), .in_read(rd[2]), .in_read_ce(rce[2]),
    .in_dout(dout), .out_full_n(full), .out_write(wr[2]), .out_write_ce(wce[2]),
    .out_din(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: holding register plus the burst/round-robin bookkeeping
  bit        known [ND];
  bit        mv    [ND];
  int        mid   [ND];
  int        mdat  [ND];
  bit        mlock [ND];
  int        mp    [ND];
  int        mc    [ND];
  int        mlast [ND];

  typedef struct {
    bit           r;
    logic [NP-1:0] e;
    bit           f;
    int           sel;
    logic [NP-1:0] rd;
    bit           cw;
    bit           wr;
    int           id;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input logic [NP-1:0] e, input bit f, input int sel,
                     input logic [NP-1:0] xrd, input bit cw, input bit xwr, input int xid);
    bit nv [ND];
    int nid [ND];
    int ndat [ND];
    bit nlock [ND];
    int np [ND];
    int nc [ND];
    int nlast [ND];
    rst  = r;
    en   = e;
    full = f;
    dout = $urandom;
    #1;
    for (int k = 0; k < ND; k++) begin
      bit acc;
      bit pop;
      bit cont;
      int g;
      logic [NP-1:0] xr;
      pop  = 0;
      cont = 0;
      g    = 0;
      acc  = !mv[k] || f;
      if (known[k]) begin
        chk($sformatf("out_write[%0d]", k), 32'(wr[k]), 32'(mv[k]));
        if (mv[k]) chk($sformatf("out_din[%0d]", k), 32'(dn[k]), 32'(mid[k] * 256 + mdat[k]));
      end
      if (!r && acc) begin
        if (mlock[k] && e[mp[k]] && mc[k] < bl[k]) begin
          g = mp[k];
          pop = 1;
          cont = 1;
        end else begin
          for (int off = 1; off <= NP; off++) begin
            int idx;
            idx = (mlast[k] + off) % NP;
            if (!pop && e[idx]) begin
              g = idx;
              pop = 1;
            end
          end
        end
      end
      xr = pop ? NP'(1) << g : '0;
      if (known[k] || r) chk($sformatf("in_read[%0d]", k), 32'(rd[k]), 32'(xr));
      if (sel == k) begin
        chk($sformatf("vec_read[%0d]", k), 32'(rd[k]), 32'(xrd));
        if (cw) begin
          chk($sformatf("vec_write[%0d]", k), 32'(wr[k]), 32'(xwr));
          if (xwr) chk($sformatf("vec_id[%0d]", k), 32'(dn[k][IW+DW-1:DW]), 32'(xid));
        end
      end
      nv[k] = mv[k]; nid[k] = mid[k]; ndat[k] = mdat[k]; nlock[k] = mlock[k];
      np[k] = mp[k]; nc[k] = mc[k]; nlast[k] = mlast[k];
      if (r) begin
        nv[k] = 0; nlock[k] = 0; nc[k] = 0; nlast[k] = NP - 1;
      end else if (acc) begin
        nv[k] = pop;
        if (pop) begin
          nid[k]  = g;
          ndat[k] = int'(dout[g*DW +: DW]);
          if (cont) begin
            nc[k] = mc[k] + 1;
          end else begin
            nc[k] = 1; nlast[k] = g; np[k] = g; nlock[k] = (bl[k] > 1);
          end
        end else begin
          nlock[k] = 0; nc[k] = 0;
        end
      end
    end
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      mv[k] = nv[k]; mid[k] = nid[k]; mdat[k] = ndat[k]; mlock[k] = nlock[k];
      mp[k] = np[k]; mc[k] = nc[k]; mlast[k] = nlast[k];
      if (r) known[k] = 1;
    end
    @(negedge clk);
  endtask

  task automatic add(input bit r, input logic [NP-1:0] e, input bit f, input int sel,
                     input logic [NP-1:0] xrd, input bit cw, input bit xwr, input int xid);
    vec_t v;
    v.r = r; v.e = e; v.f = f; v.sel = sel; v.rd = xrd; v.cw = cw; v.wr = xwr; v.id = xid;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = '0; full = 1'b1; dout = '0;
    for (int k = 0; k < ND; k++) begin
      known[k] = 0; mv[k] = 0; mid[k] = 0; mdat[k] = 0; mlock[k] = 0;
      mp[k] = 0; mc[k] = 0; mlast[k] = NP - 1;
    end

    // Pure round-robin with BURST=1
    add(1, 4'b1111, 1, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 0, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 1, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1111, 1, 0, 4'b0100, 1, 1, 1);
    add(0, 4'b1111, 1, 0, 4'b1000, 1, 1, 2);
    add(0, 4'b1111, 1, 0, 4'b0001, 1, 1, 3);
    add(0, 4'b1111, 1, 0, 4'b0010, 1, 1, 0);
    // Bursts of 4 alternating between ports 1 and 2
    add(1, 4'b0110, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 0, 0);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0110, 1, 1, 4'b0100, 1, 1, 1);
    add(0, 4'b0110, 1, 1, 4'b0100, 1, 1, 2);
    add(0, 4'b0110, 1, 1, 4'b0100, 1, 1, 2);
    add(0, 4'b0110, 1, 1, 4'b0100, 1, 1, 2);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 1, 2);
    add(0, 4'b0110, 1, 1, 4'b0010, 1, 1, 1);
    // Locked port empties early: same-cycle hand-over, no bubble
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0);
    add(0, 4'b1110, 1, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b1110, 1, 1, 4'b0010, 1, 1, 1);
    // Back-pressure for 5 cycles, then drain and pop together
    add(1, 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 0, 1, 4'b0000, 1, 1, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0);
    // Single active port with BURST=2 re-granted through wrap-around
    add(1, 4'b1000, 1, 2, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 1, 2, 4'b1000, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b1000, 1, 2, 4'b1000, 1, 1, 3);
    // Reset while locked on port 2 with a held word
    add(1, 4'b0100, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 4'b0100, 1, 0, 0);
    add(0, 4'b0100, 1, 1, 4'b0100, 1, 1, 2);
    add(1, 4'b1111, 1, 1, 4'b0000, 1, 1, 2);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 0, 0);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 1, 0);

    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("in_read_ce[%0d]", k), 32'(rce[k]), 32'hF);
      chk($sformatf("out_write_ce[%0d]", k), 32'(wce[k]), 32'h1);
    end

    foreach (tv[i]) begin
      cyc(tv[i].r, tv[i].e, tv[i].f, tv[i].sel, tv[i].rd, tv[i].cw, tv[i].wr, tv[i].id);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r;
      logic [NP-1:0] e;
      bit f;
      r = ($urandom_range(0, 149) == 0);
      e = (i % 500 < 250) ? NP'($urandom) : NP'($urandom & $urandom);
      f = ($urandom_range(0, 3) != 0);
      cyc(r, e, f, -1, '0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
